a2d_intf: RTL

- SPI master that services the off-chip 12-bit A2D converter and produces the load-cell readings `lft_ld` and `rght_ld` consumed by rider-detect/steer-enable logic.
- It also produces the `steer_pot` and `batt` readings.
- Each `nxt` request performs one conversion of the next channel in a fixed round-robin order: `lft_ld` → `rght_ld` → `steer_pot` → `batt` → `lft_ld`.
- Each conversion is two back-to-back 16-bit SPI transactions: a command frame, then a read frame.

---
 rtl/a2d_intf.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/a2d_intf.sv
// SPI master for the off-chip 12-bit A2D: round-robin conversion of the two load cells,
// the steering pot and the battery, each as a command frame followed by a read frame.
module a2d_intf #(
  parameter int unsigned SCLK_DIV_W  = 5,
  parameter int unsigned FRONT_PORCH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt
);

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RES_W     = 12;
  localparam int unsigned BIT_CNT_W = 5;
  localparam int unsigned NUM_CH    = 4;

  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  // Divider is loaded one clk before SS_n falls, so it reaches zero FRONT_PORCH clk after it.
  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD =
    SCLK_DIV_W'((2 ** SCLK_DIV_W) - FRONT_PORCH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_e;

  state_e                 state_q, state_d;
  logic                   ss_n_q, ss_n_d;
  logic                   sclk_q, sclk_d;
  logic                   cmplt_q, cmplt_d;
  logic [SCLK_DIV_W-1:0]  div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shft_q, shft_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [RES_W-1:0]       res_q [NUM_CH];
  logic [RES_W-1:0]       res_d [NUM_CH];
  logic [2:0]             chnl;
  logic                   rise_pt, fall_pt, frm_done;

  // Round-robin pointer to physical A2D channel
  always_comb begin
    chnl = 3'd0;
    case (ptr_q)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd4;
      2'd2:    chnl = 3'd5;
      default: chnl = 3'd6;
    endcase
  end

  assign rise_pt  = (div_q == DIV_RISE);
  assign fall_pt  = (div_q == DIV_FALL);
  assign frm_done = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d   = state_q;
    ss_n_d    = ss_n_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shft_d    = shft_q;
    ptr_d     = ptr_q;
    res_d     = res_q;
    cmplt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d   = CMD;
          shft_d    = {2'b00, chnl, 11'h000};
          div_d     = DIV_LOAD;
          bit_cnt_d = '0;
        end
      end
      GAP: begin
        state_d   = READ;
        shft_d    = '0;
        div_d     = DIV_LOAD;
        bit_cnt_d = '0;
      end
      CMD, READ: begin
        ss_n_d = 1'b0;
        div_d  = div_q + SCLK_DIV_W'(1);
        if (rise_pt && !frm_done) begin
          shft_d[0] = MISO;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
        // Falling point: end the frame with SCLK held high, else shift (skipping the first fall)
        if (fall_pt) begin
          if (frm_done) begin
            ss_n_d = 1'b1;
            if (state_q == CMD) begin
              state_d = GAP;
            end else begin
              state_d        = IDLE;
              res_d[ptr_q]   = shft_q[RES_W-1:0];
              cmplt_d        = 1'b1;
              ptr_d          = ptr_q + 2'd1;
            end
          end else if (bit_cnt_q != '0) begin
            shft_d = {shft_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sclk_d = ss_n_d | div_d[SCLK_DIV_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      cmplt_q   <= 1'b0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shft_q    <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      cmplt_q   <= cmplt_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shft_q    <= shft_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= res_d[i];
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = shft_q[DATA_W-1];
  assign cnv_cmplt = cmplt_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule
